bg_shift_streamer: RTL and testbench

- Reader-side counterpart of the base-graph shift calculator.
- Accepts the parallel arrays of Zc-reduced shift values (BG1 or BG2) and their calc-valid flags.
- Streams the entries out one per handshake to the downstream cyclic-shift datapath of the LDPC encoder, with a last flag and a done pulse.
- Holds busy so the upstream controller does not restart a calculation while entries are being consumed.

---
 rtl/bg_shift_streamer.sv | 227 ++++++++++++++++++++++
 tb/tb_bg_shift_streamer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_shift_streamer.sv
// Streams Zc-reduced BG1/BG2 shift arrays one entry per valid/ready handshake.
// Optional build macro SHIFT_SKIP_ZERO_EN: zero entries are skipped and counted on o_skip_cnt.
module bg_shift_streamer #(
    parameter int unsigned BG1_N = 316,
    parameter int unsigned BG2_N = 197,
    parameter int unsigned SW    = 9
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [SW-1:0] i_bg1_calc_out [BG1_N],
    input  logic [SW-1:0] i_bg2_calc_out [BG2_N],
    input  logic          i_bg1_calc_valid,
    input  logic          i_bg2_calc_valid,
    output logic [SW-1:0] o_shift_out,
    output logic          o_shift_valid,
    input  logic          i_shift_ready,
    output logic          o_shift_last,
    output logic          o_bg_sel,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err_overrun
`ifdef SHIFT_SKIP_ZERO_EN
    ,
    output logic [9:0]    o_skip_cnt
`endif
);

    localparam int unsigned AW1   = (BG1_N > 1) ? $clog2(BG1_N) : 1;
    localparam int unsigned AW2   = (BG2_N > 1) ? $clog2(BG2_N) : 1;
    localparam logic [9:0]  LAST1 = 10'(BG1_N - 1);
    localparam logic [9:0]  LAST2 = 10'(BG2_N - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e        r_state, w_state_nxt;
    logic [9:0]    r_idx, w_idx_nxt;
    logic          r_prev1, r_prev2;
    logic [SW-1:0] r_shift_out, w_out_nxt;
    logic          r_shift_valid, w_valid_nxt;
    logic          r_shift_last, w_last_nxt;
    logic          r_bg_sel, w_sel_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_err, w_err_nxt;

    logic          w_s1, w_s2;
    logic [9:0]    w_last1, w_last2, w_last_idx, w_start_last, w_nidx;
    logic          w_any1, w_any2, w_start_any;
    logic [SW-1:0] w_nval, w_start_val;
    logic          w_nval_nz, w_start_nz;

    assign w_s1 = i_bg1_calc_valid & ~r_prev1;
    assign w_s2 = i_bg2_calc_valid & ~r_prev2;

`ifdef SHIFT_SKIP_ZERO_EN
    logic [9:0] r_skip, w_skip_nxt;
    logic [9:0] w_last_n;

    // Index of the final non-zero entry decides shift_last and the end of the stream.
    always_comb begin
        w_last1 = '0;
        w_any1  = 1'b0;
        for (int unsigned i = 0; i < BG1_N; i++) begin
            if (|i_bg1_calc_out[i]) begin
                w_last1 = 10'(i);
                w_any1  = 1'b1;
            end
        end
        w_last2 = '0;
        w_any2  = 1'b0;
        for (int unsigned i = 0; i < BG2_N; i++) begin
            if (|i_bg2_calc_out[i]) begin
                w_last2 = 10'(i);
                w_any2  = 1'b1;
            end
        end
    end

    assign w_nval_nz  = |w_nval;
    assign w_start_nz = |w_start_val;
    assign w_last_n   = r_bg_sel ? LAST2 : LAST1;
    assign o_skip_cnt = r_skip;
`else
    assign w_last1    = LAST1;
    assign w_last2    = LAST2;
    assign w_any1     = 1'b1;
    assign w_any2     = 1'b1;
    assign w_nval_nz  = 1'b1;
    assign w_start_nz = 1'b1;
`endif

    assign w_last_idx   = r_bg_sel ? w_last2 : w_last1;
    assign w_nidx       = (r_idx == w_last_idx) ? r_idx : r_idx + 10'd1;
    assign w_start_val  = w_s2 ? i_bg2_calc_out[0] : i_bg1_calc_out[0];
    assign w_start_last = w_s2 ? w_last2 : w_last1;
    assign w_start_any  = w_s2 ? w_any2 : w_any1;

    always_comb begin
        w_nval = '0;
        if (r_bg_sel) begin
            w_nval = i_bg2_calc_out[w_nidx[AW2-1:0]];
        end else begin
            w_nval = i_bg1_calc_out[w_nidx[AW1-1:0]];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_out_nxt   = r_shift_out;
        w_valid_nxt = r_shift_valid;
        w_last_nxt  = r_shift_last;
        w_sel_nxt   = r_bg_sel;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
`ifdef SHIFT_SKIP_ZERO_EN
        w_skip_nxt  = r_skip;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_s1 && w_s2) begin
                    w_err_nxt = 1'b1;
                end else if (w_s1 || w_s2) begin
                    w_sel_nxt  = w_s2;
                    w_idx_nxt  = '0;
                    w_busy_nxt = 1'b1;
`ifdef SHIFT_SKIP_ZERO_EN
                    w_skip_nxt = '0;
`endif
                    if (!w_start_any) begin
                        w_state_nxt = StDone;
                        w_done_nxt  = 1'b1;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
`ifdef SHIFT_SKIP_ZERO_EN
                        w_skip_nxt  = w_s2 ? 10'(BG2_N) : 10'(BG1_N);
`endif
                    end else begin
                        w_state_nxt = StStream;
                        w_out_nxt   = w_start_val;
                        w_valid_nxt = w_start_nz;
                        w_last_nxt  = w_start_nz && (w_start_last == 10'd0);
                    end
                end
            end
            StStream: begin
                if (w_s1 || w_s2) w_err_nxt = 1'b1;
`ifdef SHIFT_SKIP_ZERO_EN
                // Valid low in STREAM means the current entry is a zero being stepped over.
                if (!r_shift_valid) begin
                    w_idx_nxt   = w_nidx;
                    w_skip_nxt  = r_skip + 10'd1;
                    w_out_nxt   = w_nval;
                    w_valid_nxt = w_nval_nz;
                    w_last_nxt  = w_nval_nz && (w_nidx == w_last_idx);
                end else
`endif
                if (i_shift_ready) begin
                    if (r_idx == w_last_idx) begin
                        w_state_nxt = StDone;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
`ifdef SHIFT_SKIP_ZERO_EN
                        w_skip_nxt  = r_skip + (w_last_n - r_idx);
`endif
                    end else begin
                        w_idx_nxt   = w_nidx;
                        w_out_nxt   = w_nval;
                        w_valid_nxt = w_nval_nz;
                        w_last_nxt  = w_nval_nz && (w_nidx == w_last_idx);
                    end
                end
            end
            StDone: begin
                if (w_s1 || w_s2) w_err_nxt = 1'b1;
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_idx         <= '0;
            r_prev1       <= 1'b0;
            r_prev2       <= 1'b0;
            r_shift_out   <= '0;
            r_shift_valid <= 1'b0;
            r_shift_last  <= 1'b0;
            r_bg_sel      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
`ifdef SHIFT_SKIP_ZERO_EN
            r_skip        <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_prev1       <= i_bg1_calc_valid;
            r_prev2       <= i_bg2_calc_valid;
            r_shift_out   <= w_out_nxt;
            r_shift_valid <= w_valid_nxt;
            r_shift_last  <= w_last_nxt;
            r_bg_sel      <= w_sel_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
`ifdef SHIFT_SKIP_ZERO_EN
            r_skip        <= w_skip_nxt;
`endif
        end
    end

    assign o_shift_out   = r_shift_out;
    assign o_shift_valid = r_shift_valid;
    assign o_shift_last  = r_shift_last;
    assign o_bg_sel      = r_bg_sel;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err_overrun = r_err;

endmodule

// File: tb/tb_bg_shift_streamer.sv
// Scoreboard bench for bg_shift_streamer: directed streams, handshake stalls, overrun and reset.
// Also exercises the SHIFT_SKIP_ZERO_EN build when that macro is defined.
module tb_bg_shift_streamer;

    localparam int BG1_N = 316;
    localparam int BG2_N = 197;
    localparam int SW    = 9;
`ifdef SHIFT_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [SW-1:0] v;
        logic          last;
        logic          sel;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] bg1 [BG1_N];
    logic [SW-1:0] bg2 [BG2_N];
    logic          bg1_valid, bg2_valid;
    logic [SW-1:0] shift_out;
    logic          shift_valid, shift_ready, shift_last, bg_sel, busy, done, err;
`ifdef SHIFT_SKIP_ZERO_EN
    logic [9:0]    skip_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t e;
    logic          mon_hold = 1'b0;
    logic [SW-1:0] hold_out;
    logic          hold_last;

    bg_shift_streamer #(.BG1_N(BG1_N), .BG2_N(BG2_N), .SW(SW)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_bg1_calc_out   (bg1),
        .i_bg2_calc_out   (bg2),
        .i_bg1_calc_valid (bg1_valid),
        .i_bg2_calc_valid (bg2_valid),
        .o_shift_out      (shift_out),
        .o_shift_valid    (shift_valid),
        .i_shift_ready    (shift_ready),
        .o_shift_last     (shift_last),
        .o_bg_sel         (bg_sel),
        .o_busy           (busy),
        .o_done           (done),
        .o_err_overrun    (err)
`ifdef SHIFT_SKIP_ZERO_EN
        ,
        .o_skip_cnt       (skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: handshakes complete on the next rising edge, so sample on the falling edge.
    always @(negedge clk) begin
        if (mon_hold) begin
            checks++;
            if (!shift_valid || shift_out !== hold_out || shift_last !== hold_last) begin
                errors++;
                $display("FAIL stall hold: got v=%0d last=%b valid=%b expected v=%0d last=%b valid=1",
                         shift_out, shift_last, shift_valid, hold_out, hold_last);
            end
        end
        mon_hold = 1'b0;
        if (shift_valid && !shift_ready) begin
            mon_hold  = 1'b1;
            hold_out  = shift_out;
            hold_last = shift_last;
        end
        if (shift_valid && shift_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected entry: got v=%0d sel=%b expected no entry", shift_out, bg_sel);
            end else begin
                e = sb.pop_front();
                if (shift_out !== e.v || shift_last !== e.last || bg_sel !== e.sel) begin
                    errors++;
                    $display("FAIL entry: got v=%0d last=%b sel=%b expected v=%0d last=%b sel=%b",
                             shift_out, shift_last, bg_sel, e.v, e.last, e.sel);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Queue every entry with index < upto; shift_last goes on the final presented entry.
    task automatic push_stream(input bit sel, input int upto);
        int n;
        int lastnz;
        logic [SW-1:0] v;
        exp_t x;
        n = sel ? BG2_N : BG1_N;
        lastnz = -1;
        for (int i = 0; i < n; i++) begin
            v = sel ? bg2[i] : bg1[i];
            if (!SKIP || v != 0) lastnz = i;
        end
        for (int i = 0; i < n && i < upto; i++) begin
            v = sel ? bg2[i] : bg1[i];
            if (!SKIP || v != 0) begin
                x.v = v;
                x.last = (i == lastnz);
                x.sel = sel;
                sb.push_back(x);
            end
        end
    endtask

    task automatic run_to_done(input bit toggle, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
            if (toggle) shift_ready = ~shift_ready;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic check_after_done(input string name, input int prev_done);
        tick();
        check({name, " done pulse count"}, done_cnt, prev_done + 1);
        check({name, " done low"}, {31'd0, done}, 0);
        check({name, " busy low"}, {31'd0, busy}, 0);
        check({name, " scoreboard empty"}, sb.size(), 0);
    endtask

    initial begin
        int n;
        int d0;
        rst = 1'b0;
        bg1_valid = 1'b0;
        bg2_valid = 1'b0;
        shift_ready = 1'b0;
        for (int i = 0; i < BG1_N; i++) bg1[i] = SW'(i);
        for (int i = 0; i < BG2_N; i++) bg2[i] = SW'(511 - i);
        #1 rst = 1'b1;
        #1;
        check("reset valid", {31'd0, shift_valid}, 0);
        check("reset out", {23'd0, shift_out}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset flags", {28'd0, shift_last, bg_sel, done, err}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Full BG1 stream with ready held high.
        shift_ready = 1'b1;
        push_stream(1'b0, BG1_N);
        d0 = done_cnt;
        bg1_valid = 1'b1;
        tick();
        check("bg1 busy after start", {31'd0, busy}, 1);
        check("bg1 entry0 sel", {31'd0, bg_sel}, 0);
        run_to_done(1'b0, 1000, n);
        check("bg1 done latency", n, BG1_N);
        check_after_done("bg1", d0);
        check("err clear after bg1", {31'd0, err}, 0);

        // BG2 stream with ready alternating 1,0,1,0.
        bg1_valid = 1'b0;
        push_stream(1'b1, BG2_N);
        d0 = done_cnt;
        bg2_valid = 1'b1;
        tick();
        check("bg2 sel", {31'd0, bg_sel}, 1);
        run_to_done(1'b1, 1000, n);
        shift_ready = 1'b1;
        check_after_done("bg2", d0);
        check("err clear after bg2", {31'd0, err}, 0);

        // Simultaneous rising edges.
        bg2_valid = 1'b0;
        tick();
        bg1_valid = 1'b1;
        bg2_valid = 1'b1;
        tick();
        tick();
        check("dual start busy", {31'd0, busy}, 0);
        check("dual start valid", {31'd0, shift_valid}, 0);
        check("dual start err", {31'd0, err}, 1);

        rst = 1'b1;
        bg1_valid = 1'b0;
        bg2_valid = 1'b0;
        #1;
        check("reset clears err", {31'd0, err}, 0);
        tick();
        rst = 1'b0;
        tick();

        // BG2 edge while BG1 is at idx 50: BG1 completes, no BG2 stream.
        push_stream(1'b0, BG1_N);
        d0 = done_cnt;
        bg1_valid = 1'b1;
        repeat (51) tick();
        check("bg1 at idx50", {23'd0, shift_out}, 50);
        bg2_valid = 1'b1;
        tick();
        check("overrun err", {31'd0, err}, 1);
        check("overrun sel", {31'd0, bg_sel}, 0);
        run_to_done(1'b0, 1000, n);
        check_after_done("overrun bg1", d0);
        repeat (5) tick();
        check("no bg2 after overrun", {31'd0, shift_valid}, 0);
        check("err sticky", {31'd0, err}, 1);

        // Reset at idx 100, then restart from entry 0.
        bg1_valid = 1'b0;
        bg2_valid = 1'b0;
        tick();
        push_stream(1'b0, 100);
        bg1_valid = 1'b1;
        repeat (101) tick();
        check("bg1 at idx100", {23'd0, shift_out}, 100);
        rst = 1'b1;
        bg1_valid = 1'b0;
        #1;
        check("midreset valid", {31'd0, shift_valid}, 0);
        check("midreset out", {23'd0, shift_out}, 0);
        check("midreset busy", {31'd0, busy}, 0);
        check("midreset flags", {28'd0, shift_last, bg_sel, done, err}, 0);
        check("midreset scoreboard", sb.size(), 0);
        tick();
        rst = 1'b0;
        tick();
        push_stream(1'b0, BG1_N);
        d0 = done_cnt;
        bg1_valid = 1'b1;
        run_to_done(1'b0, 1000, n);
        check("restart latency", n, BG1_N + 1);
        check_after_done("restart", d0);

`ifdef SHIFT_SKIP_ZERO_EN
        // Zeros at 0, 5 and 196 of BG2: 194 entries, last on 195, three skipped.
        bg1_valid = 1'b0;
        tick();
        bg2[0] = '0;
        bg2[5] = '0;
        bg2[196] = '0;
        push_stream(1'b1, BG2_N);
        check("skip expected count", sb.size(), 194);
        d0 = done_cnt;
        bg2_valid = 1'b1;
        run_to_done(1'b0, 1000, n);
        check("skip cnt", {22'd0, skip_cnt}, 3);
        check_after_done("skip", d0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 ns");
        $fatal(1);
    end

endmodule
